// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port SRAM between NUM_REQ requesters. Read and write
// ports are arbitrated independently; read data is steered back through an owner-tag FIFO.
module sram_port_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                             i_clk,
    input  logic                             i_nrst,

    input  logic [NUM_REQ-1:0]               i_rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_rd_addr,
    output logic [NUM_REQ-1:0]               o_rd_gnt,
    output logic [DATA_WIDTH-1:0]            o_rd_data,
    output logic [NUM_REQ-1:0]               o_rd_valid,

    input  logic [NUM_REQ-1:0]               i_wr_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_wr_data,
    output logic [NUM_REQ-1:0]               o_wr_gnt,

    output logic                             o_sram_write_en,
    output logic [ADDR_WIDTH-1:0]            o_sram_write_addr,
    output logic [DATA_WIDTH-1:0]            o_sram_data_in,
    output logic                             o_sram_read_en,
    output logic [ADDR_WIDTH-1:0]            o_sram_read_addr,
    input  logic [DATA_WIDTH-1:0]            i_sram_data_out,
    input  logic                             i_sram_data_out_valid,

    output logic                             o_err_unexpected
);

    localparam int unsigned PtrW   = $clog2(NUM_REQ);
    localparam int unsigned FifoAw = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW   = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [PtrW-1:0]   idx_t;
    typedef logic [FifoAw-1:0] fptr_t;
    typedef logic [CntW-1:0]   cnt_t;

    // (base + off) mod NUM_REQ, valid for base, off < NUM_REQ.
    function automatic idx_t wrap_add(input idx_t base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return idx_t'(sum);
    endfunction

    function automatic void rr_pick(input  logic [NUM_REQ-1:0] req,
                                    input  idx_t               ptr,
                                    output logic               found,
                                    output idx_t               idx);
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[wrap_add(ptr, i)]) begin
                found = 1'b1;
                idx   = wrap_add(ptr, i);
            end
        end
    endfunction

    function automatic fptr_t fifo_inc(input fptr_t p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + fptr_t'(1);
    endfunction

    // State
    idx_t                  rd_ptr_q, rd_ptr_d;
    idx_t                  wr_ptr_q, wr_ptr_d;
    idx_t                  tag_q [MAX_OUTSTANDING];
    idx_t                  tag_d [MAX_OUTSTANDING];
    fptr_t                 fifo_wp_q, fifo_wp_d;
    fptr_t                 fifo_rp_q, fifo_rp_d;
    cnt_t                  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    // Arbitration
    logic rd_found, wr_found;
    idx_t rd_idx, wr_idx;
    logic fifo_full, fifo_empty;
    logic rd_push, rd_pop;

    always_comb begin
        rd_found = 1'b0;
        rd_idx   = '0;
        wr_found = 1'b0;
        wr_idx   = '0;
        rr_pick(i_rd_req, rd_ptr_q, rd_found, rd_idx);
        rr_pick(i_wr_req, wr_ptr_q, wr_found, wr_idx);
    end

    assign fifo_full  = (32'(cnt_q) == MAX_OUTSTANDING);
    assign fifo_empty = (cnt_q == '0);
    // Grant decision uses the pre-pop count, so a pop on a full FIFO does not admit a read.
    assign rd_push    = rd_found && !fifo_full;
    assign rd_pop     = i_sram_data_out_valid && !fifo_empty;

    always_comb begin
        o_rd_gnt = '0;
        o_wr_gnt = '0;
        if (rd_push) begin
            o_rd_gnt[rd_idx] = 1'b1;
        end
        if (wr_found) begin
            o_wr_gnt[wr_idx] = 1'b1;
        end
    end

    always_comb begin
        o_rd_valid = '0;
        if (rd_pop) begin
            o_rd_valid[tag_q[fifo_rp_q]] = 1'b1;
        end
    end

    assign o_rd_data = i_sram_data_out_valid ? i_sram_data_out : '0;

    // Next-state
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        tag_d     = tag_q;
        fifo_wp_d = fifo_wp_q;
        fifo_rp_d = fifo_rp_q;
        cnt_d     = cnt_q;
        err_d     = err_q | (i_sram_data_out_valid & fifo_empty);
        rd_en_d   = rd_push;
        rd_addr_d = rd_addr_q;
        wr_en_d   = wr_found;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (rd_push) begin
            rd_ptr_d           = wrap_add(rd_idx, 1);
            rd_addr_d          = i_rd_addr[rd_idx * ADDR_WIDTH +: ADDR_WIDTH];
            tag_d[fifo_wp_q]   = rd_idx;
            fifo_wp_d          = fifo_inc(fifo_wp_q);
        end
        if (rd_pop) begin
            fifo_rp_d = fifo_inc(fifo_rp_q);
        end
        unique case ({rd_push, rd_pop})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase

        if (wr_found) begin
            wr_ptr_d  = wrap_add(wr_idx, 1);
            wr_addr_d = i_wr_addr[wr_idx * ADDR_WIDTH +: ADDR_WIDTH];
            wr_data_d = i_wr_data[wr_idx * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_q[i] <= '0;
            end
            fifo_wp_q <= '0;
            fifo_rp_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            tag_q     <= tag_d;
            fifo_wp_q <= fifo_wp_d;
            fifo_rp_q <= fifo_rp_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_sram_read_en    = rd_en_q;
    assign o_sram_read_addr  = rd_addr_q;
    assign o_sram_write_en   = wr_en_q;
    assign o_sram_write_addr = wr_addr_q;
    assign o_sram_data_in    = wr_data_q;
    assign o_err_unexpected  = err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and randomized bench for sram_port_arbiter against a queue-based reference model
// with a simple in-order SRAM responder.
module tb_sram_port_arbiter;

    localparam int unsigned NUM_REQ         = 4;
    localparam int unsigned ADDR_WIDTH      = 16;
    localparam int unsigned DATA_WIDTH      = 64;
    localparam int unsigned MAX_OUTSTANDING = 4;

    logic                          clk  = 1'b0;
    logic                          nrst = 1'b1;
    logic [NUM_REQ-1:0]            rd_req  = '0;
    logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr = '0;
    logic [NUM_REQ-1:0]            wr_req  = '0;
    logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] wr_data = '0;
    logic [NUM_REQ-1:0]            rd_gnt, wr_gnt, rd_valid;
    logic [DATA_WIDTH-1:0]         rd_data, sram_din;
    logic [DATA_WIDTH-1:0]         sram_dout = '0;
    logic                          sram_dv   = 1'b0;
    logic                          sram_we, sram_re, err;
    logic [ADDR_WIDTH-1:0]         sram_waddr, sram_raddr;

    sram_port_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .i_clk                 (clk),
        .i_nrst                (nrst),
        .i_rd_req              (rd_req),
        .i_rd_addr             (rd_addr),
        .o_rd_gnt              (rd_gnt),
        .o_rd_data             (rd_data),
        .o_rd_valid            (rd_valid),
        .i_wr_req              (wr_req),
        .i_wr_addr             (wr_addr),
        .i_wr_data             (wr_data),
        .o_wr_gnt              (wr_gnt),
        .o_sram_write_en       (sram_we),
        .o_sram_write_addr     (sram_waddr),
        .o_sram_data_in        (sram_din),
        .o_sram_read_en        (sram_re),
        .o_sram_read_addr      (sram_raddr),
        .i_sram_data_out       (sram_dout),
        .i_sram_data_out_valid (sram_dv),
        .o_err_unexpected      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: round-robin pointers as plain ints, outstanding reads as queues.
    int                    rptr_m, wptr_m;
    int                    tag_m[$];
    logic [ADDR_WIDTH-1:0] taga_m[$];
    bit                    err_m;

    // SRAM responder: one-cycle minimum latency, in order.
    logic [ADDR_WIDTH-1:0] sram_q[$];
    bit                    staged_v;
    logic [ADDR_WIDTH-1:0] staged_a;
    bit                    hold, force_resp, rand_resp;

    logic [NUM_REQ-1:0]    last_rd_gnt, last_wr_gnt, last_rd_valid;
    int                    grant_log[$], owner_log[$];
    logic [63:0]           data_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [ADDR_WIDTH-1:0] a);
        return {a, 16'hC0DE, ~a, a ^ 16'h5A5A};
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] req, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int k);
        logic [NUM_REQ-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    function automatic int idx_of(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Entered just after a rising edge with inputs set; leaves just after the next one.
    task automatic run_cycle();
        logic [NUM_REQ-1:0]    exp_rv;
        logic [ADDR_WIDTH-1:0] ra, wa, dummy_a;
        logic [63:0]           wd;
        int                    exp_rk, exp_wk, dummy_t;
        bit                    resp;
        resp = force_resp ||
               (!hold && sram_q.size() > 0 && (!rand_resp || $urandom_range(0, 1) == 1));
        sram_dv   = resp;
        sram_dout = !resp ? '0 : (sram_q.size() > 0) ? data_of(sram_q[0])
                                                     : {$urandom, $urandom};
        exp_wk = pick(wr_req, wptr_m);
        exp_rk = (tag_m.size() < MAX_OUTSTANDING) ? pick(rd_req, rptr_m) : -1;
        exp_rv = '0;
        if (resp && tag_m.size() > 0) exp_rv[tag_m[0]] = 1'b1;
        ra = (exp_rk >= 0) ? rd_addr[exp_rk*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        wa = (exp_wk >= 0) ? wr_addr[exp_wk*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        wd = (exp_wk >= 0) ? wr_data[exp_wk*DATA_WIDTH +: DATA_WIDTH] : '0;

        @(negedge clk);
        last_rd_gnt   = rd_gnt;
        last_wr_gnt   = wr_gnt;
        last_rd_valid = rd_valid;
        if (rd_gnt != '0) grant_log.push_back(idx_of(rd_gnt));
        if (rd_valid != '0) begin
            owner_log.push_back(idx_of(rd_valid));
            data_log.push_back(rd_data);
        end
        check("rd_gnt", rd_gnt, onehot(exp_rk));
        check("wr_gnt", wr_gnt, onehot(exp_wk));
        check("rd_valid", rd_valid, exp_rv);
        if (exp_rv != '0) check("rd_data", rd_data, data_of(taga_m[0]));
        check("err_pre", err, err_m);

        @(posedge clk);
        #1;
        if (resp) begin
            if (tag_m.size() > 0) begin
                dummy_t = tag_m.pop_front();
                dummy_a = taga_m.pop_front();
            end else begin
                err_m = 1'b1;
            end
        end
        if (exp_rk >= 0) begin
            rptr_m = (exp_rk + 1) % NUM_REQ;
            tag_m.push_back(exp_rk);
            taga_m.push_back(ra);
            rd_req[exp_rk] = 1'b0;
        end
        if (exp_wk >= 0) begin
            wptr_m = (exp_wk + 1) % NUM_REQ;
            wr_req[exp_wk] = 1'b0;
        end
        check("sram_re", sram_re, exp_rk >= 0);
        if (exp_rk >= 0) check("sram_raddr", sram_raddr, ra);
        check("sram_we", sram_we, exp_wk >= 0);
        if (exp_wk >= 0) begin
            check("sram_waddr", sram_waddr, wa);
            check("sram_din", sram_din, wd);
        end
        check("err_post", err, err_m);

        if (resp && sram_q.size() > 0) dummy_a = sram_q.pop_front();
        if (staged_v) sram_q.push_back(staged_a);
        staged_v   = sram_re;
        staged_a   = sram_raddr;
        force_resp = 1'b0;
        sram_dv    = 1'b0;
    endtask

    task automatic do_reset(input bit clear_env);
        nrst = 1'b0;
        #1;
        check("rst_re", sram_re, 0);
        check("rst_we", sram_we, 0);
        check("rst_raddr", sram_raddr, 0);
        check("rst_waddr", sram_waddr, 0);
        check("rst_din", sram_din, 0);
        check("rst_err", err, 0);
        rptr_m = 0;
        wptr_m = 0;
        tag_m.delete();
        taga_m.delete();
        err_m = 1'b0;
        if (clear_env) begin
            sram_q.delete();
            staged_v = 1'b0;
        end
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        owner_log.delete();
        data_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        hold = 1'b0; force_resp = 1'b0; rand_resp = 1'b0; staged_v = 1'b0;
        #2;
        do_reset(1'b1);

        // Single write from requester 2.
        wr_req = 4'b0100;
        wr_addr[2*ADDR_WIDTH +: ADDR_WIDTH] = 16'd2;
        wr_data[2*DATA_WIDTH +: DATA_WIDTH] = 64'hDEADBEEF00000002;
        run_cycle();
        check("t1_wr_gnt", last_wr_gnt, 4'b0100);
        check("t1_we", sram_we, 1);
        check("t1_waddr", sram_waddr, 16'd2);
        check("t1_wdata", sram_din, 64'hDEADBEEF00000002);
        run_cycle();

        // All requesters read continuously for 8 cycles.
        clear_logs();
        for (int k = 0; k < NUM_REQ; k++) rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = 16'(16'h100 + k);
        for (int c = 0; c < 8; c++) begin
            rd_req = 4'hF;
            run_cycle();
        end
        rd_req = '0;
        for (int c = 0; c < 4; c++) run_cycle();
        check("t3_gnt_len", grant_log.size(), 8);
        check("t3_own_len", owner_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("t3_gnt_seq", (i < grant_log.size()) ? grant_log[i] : 99, i % 4);
            check("t3_own_seq", (i < owner_log.size()) ? owner_log[i] : 99, i % 4);
        end

        // Requesters 1 and 3 read addresses 5 and 7.
        clear_logs();
        rd_addr[1*ADDR_WIDTH +: ADDR_WIDTH] = 16'd5;
        rd_addr[3*ADDR_WIDTH +: ADDR_WIDTH] = 16'd7;
        rd_req = 4'b1010;
        for (int c = 0; c < 6; c++) run_cycle();
        check("t4_len", owner_log.size(), 2);
        check("t4_own0", (owner_log.size() > 0) ? owner_log[0] : 99, 1);
        check("t4_dat0", (data_log.size() > 0) ? data_log[0] : '0, data_of(16'd5));
        check("t4_own1", (owner_log.size() > 1) ? owner_log[1] : 99, 3);
        check("t4_dat1", (data_log.size() > 1) ? data_log[1] : '0, data_of(16'd7));

        // Tag FIFO full: five reads with responses held off.
        hold = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = 16'(16'd10 + k);
        rd_req = 4'hF;
        for (int c = 0; c < 4; c++) run_cycle();
        rd_req[0] = 1'b1;
        rd_addr[0 +: ADDR_WIDTH] = 16'd20;
        run_cycle();
        check("t5_full_gnt", last_rd_gnt, 4'b0000);
        run_cycle();
        check("t5_full_gnt2", last_rd_gnt, 4'b0000);
        hold = 1'b0;
        run_cycle();
        hold = 1'b1;
        check("t5_pop_gnt", last_rd_gnt, 4'b0000);
        check("t5_pop_owner", last_rd_valid, 4'b0001);
        run_cycle();
        check("t5_after_pop_gnt", last_rd_gnt, 4'b0001);
        hold = 1'b0;
        for (int c = 0; c < 8; c++) run_cycle();

        // Unexpected response with nothing outstanding.
        force_resp = 1'b1;
        run_cycle();
        check("t6_valid", last_rd_valid, 4'b0000);
        check("t6_err", err, 1);
        for (int c = 0; c < 3; c++) run_cycle();
        check("t6_err_sticky", err, 1);
        do_reset(1'b1);

        // Reset with two reads in flight.
        hold = 1'b1;
        rd_addr[0 +: ADDR_WIDTH] = 16'd30;
        rd_addr[ADDR_WIDTH +: ADDR_WIDTH] = 16'd31;
        rd_req = 4'b0011;
        run_cycle();
        run_cycle();
        check("t7_re_before", sram_re, 1);
        rd_req = '0;
        do_reset(1'b0);
        clear_logs();
        hold = 1'b0;
        for (int c = 0; c < 4; c++) run_cycle();
        check("t7_stale_err", err, 1);
        check("t7_stale_owners", owner_log.size(), 0);
        hold = 1'b1;
        rd_req = 4'hF;
        wr_req = 4'hF;
        run_cycle();
        check("t7_rd_prio", last_rd_gnt, 4'b0001);
        check("t7_wr_prio", last_wr_gnt, 4'b0001);
        rd_req = '0;
        wr_req = '0;
        hold = 1'b0;
        for (int c = 0; c < 6; c++) run_cycle();
        do_reset(1'b1);

        // Randomized traffic with random response timing.
        rand_resp = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!rd_req[k] && $urandom_range(0, 2) == 0) begin
                    rd_req[k] = 1'b1;
                    rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = 16'($urandom);
                end
                if (!wr_req[k] && $urandom_range(0, 2) == 0) begin
                    wr_req[k] = 1'b1;
                    wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = 16'($urandom);
                    wr_data[k*DATA_WIDTH +: DATA_WIDTH] = {$urandom, $urandom};
                end
            end
            hold = ($urandom_range(0, 7) == 0);
            run_cycle();
        end
        rd_req = '0;
        wr_req = '0;
        hold = 1'b0;
        rand_resp = 1'b0;
        for (int c = 0; c < 12; c++) run_cycle();
        check("final_drained", tag_m.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
